// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline sequencing unit.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W_BITS = 2;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
    localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

    // All-zero bubble; its rd field doubles as the never-forwarded x0.
    localparam logic [31:0]      BUBBLE = 32'h0000_0000;
    localparam logic [REG_W-1:0] REG_X0 = BUBBLE[11:7];

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one E-stage source register; M wins over W.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]      rs,
    input  logic [REG_W-1:0]      rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_W-1:0]      rd_w,
    input  logic                  reg_write_w,
    output logic [FWD_W_BITS-1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward sequencing for the 5-stage pipeline, with start-up
// flush and data-memory wait handling including a sticky timeout flag.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_W-1:0]      Rs1D,
    input  logic [REG_W-1:0]      Rs2D,
    input  logic [REG_W-1:0]      Rs1E,
    input  logic [REG_W-1:0]      Rs2E,
    input  logic [REG_W-1:0]      RdE,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic [REG_W-1:0]      RdM,
    input  logic                  RegWriteM,
    input  logic                  DMemReqM,
    input  logic                  DMemReadyM,
    input  logic [REG_W-1:0]      RdW,
    input  logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [FWD_W_BITS-1:0] ForwardAE,
    output logic [FWD_W_BITS-1:0] ForwardBE,
    output logic                  Ready,
    output logic                  MemTimeout
);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    memwait;
    logic                    load_use;
    logic [FWD_W_BITS-1:0]   fwd_a;
    logic [FWD_W_BITS-1:0]   fwd_b;

    assign memwait  = DMemReqM & ~DMemReadyM;
    assign load_use = LoadE & (RdE != REG_X0) & ((RdE == Rs1D) | (RdE == Rs2D));

    forward_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    // Sequencer: start-up flush count, memory wait count, sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= '0;
            Ready      <= 1'b0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                        state <= RUN;
                        cnt   <= '0;
                        Ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (memwait) begin
                        state <= MEM_WAIT;
                        cnt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!memwait) begin
                        state <= RUN;
                    end else if (cnt != CNT_W'(MEM_TIMEOUT)) begin
                        cnt <= cnt + CNT_W'(1);
                        if ((cnt + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT)) begin
                            MemTimeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Hazard priority: memory hold, then taken branch, then load-use.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if (state == INIT) begin
            StallF    = 1'b1;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + random bench for pipeline_ctrl with a reference model and
// an expected-value queue checked mid-cycle.
module tb_pipeline_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned MT = 4;
    localparam int unsigned CW = 8;

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       LoadE, PCSrcE, RegWriteM, DMemReqM, DMemReadyM, RegWriteW;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       Ready, MemTimeout;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    int m_init_left;
    bit m_wait;
    int m_wcnt;
    bit m_ready;
    bit m_to;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM),
        .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Ready(Ready), .MemTimeout(MemTimeout)
    );

    task automatic model_reset();
        m_init_left = FC;
        m_wait      = 1'b0;
        m_wcnt      = 0;
        m_ready     = 1'b0;
        m_to        = 1'b0;
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Order: StallF D E M, FlushD E W, ForwardAE, ForwardBE, Ready, MemTimeout
    function automatic logic [12:0] expect_out();
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa, fb;
        st = 4'b0000; fl = 3'b000;
        fa = fwd_model(Rs1E);
        fb = fwd_model(Rs2E);
        if (m_init_left > 0) begin
            st = 4'b1000; fl = 3'b111; fa = 2'b00; fb = 2'b00;
        end else if (DMemReqM && !DMemReadyM) begin
            st = 4'b1111; fl = 3'b001;
        end else if (PCSrcE) begin
            fl = 3'b110;
        end else if (LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D)) begin
            st = 4'b1100; fl = 3'b010;
        end
        return {st, fl, fa, fb, m_ready, m_to};
    endfunction

    task automatic model_update();
        if (!reset) begin
            model_reset();
        end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
        end else if (DMemReqM && !DMemReadyM) begin
            if (!m_wait) begin
                m_wait = 1'b1;
                m_wcnt = 0;
            end else if (m_wcnt < int'(MT)) begin
                m_wcnt++;
                if (m_wcnt == int'(MT)) m_to = 1'b1;
            end
        end else begin
            m_wait = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        LoadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        DMemReqM = 0; DMemReadyM = 0;
    endtask

    // Entered at posedge+1 with inputs driven; checks at negedge+1.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        got;
        logic [12:0] obs;
        if (!reset) model_reset();
        e.tag = tag;
        e.val = expect_out();
        sb.push_back(e);
        #5;
        got = sb.pop_front();
        obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, Ready, MemTimeout};
        n_assert++;
        assert (obs === got.val)
        else begin
            n_fail++;
            $error("FAIL %s observed=%013b expected=%013b", got.tag, obs, got.val);
        end
        @(posedge clk);
        #1;
        model_update();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step("reset_hold0");
        step("reset_hold1");

        reset = 1'b1;
        step("init_flush0");
        step("init_flush1");
        step("run_idle");

        RdE = 5; LoadE = 1; Rs2D = 5;
        step("load_use");
        LoadE = 0;
        step("load_use_gone");
        RdE = 0; LoadE = 1; Rs2D = 0; Rs1D = 0;
        step("load_use_x0");

        RdE = 9; Rs1D = 9; LoadE = 1; PCSrcE = 1;
        step("branch_over_load_use");
        clear_inputs();

        Rs1E = 7; RdM = 7; RegWriteM = 1; RdW = 7; RegWriteW = 1;
        step("fwd_a_m");
        RegWriteM = 0;
        step("fwd_a_w");
        Rs1E = 0; Rs2E = 0; RdM = 0; RegWriteM = 1; RdW = 0;
        step("fwd_x0");
        Rs2E = 3; RdW = 3; RdM = 4;
        step("fwd_b_w");
        clear_inputs();

        DMemReqM = 1; DMemReadyM = 1;
        step("single_cycle_mem");
        DMemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) step("mem_wait");
        DMemReadyM = 1;
        step("mem_release_branch");
        clear_inputs();
        step("after_release");

        DMemReqM = 1; DMemReadyM = 0;
        for (int i = 0; i < 10; i++) step("mem_timeout_wait");
        DMemReadyM = 1;
        step("timeout_release");
        clear_inputs();
        step("timeout_sticky0");
        step("timeout_sticky1");

        DMemReqM = 1; DMemReadyM = 0;
        for (int i = 0; i < 3; i++) step("wait_before_reset");
        reset = 1'b0;
        step("reset_mid_wait");
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) step("reinit");

        for (int i = 0; i < 40; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            LoadE = 1'($urandom_range(0, 1)); PCSrcE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            DMemReqM = 1'($urandom_range(0, 1));
            DMemReadyM = ($urandom_range(0, 3) != 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing unit for the 5-stage RV32 pipeline registers (F/D, D/E, E/M, M/W). It generates stall, flush and forwarding selects for every stage from hazard inputs. After reset it runs a start-up flush sequence that clears all stages for a fixed number of cycles. It holds the pipeline on a multi-cycle data-memory access and flags a memory timeout.

Parameters:
FLUSH_CYCLES, 2, number of cycles all stages are flushed after reset release (≥1)
MEM_TIMEOUT, 255, memory-wait cycles before MemTimeout is set (≥1)
CNT_W, 8, width of the internal wait/flush counter; must hold max(FLUSH_CYCLES, MEM_TIMEOUT)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
Rs1D, Rs2D  in  5  source registers of the instruction in D
Rs1E, Rs2E  in  5  source registers of the instruction in E
RdE  in  5  destination register in E
LoadE  in  1  instruction in E is a load
PCSrcE  in  1  branch or jump taken, resolved in E
RdM  in  5  destination register in M
RegWriteM  in  1  instruction in M writes a register
DMemReqM  in  1  load or store in M is requesting data memory
DMemReadyM  in  1  data memory completes the request this cycle
RdW  in  5  destination register in W
RegWriteW  in  1  instruction in W writes a register
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  out  1  load a bubble (all-zero) into the D, E or W register
ForwardAE, ForwardBE  out  2  operand select in E: 00 regfile, 10 from M, 01 from W
Ready  out  1  start-up sequence complete
MemTimeout  out  1  sticky; memory wait reached MEM_TIMEOUT

Behaviour:
- Registered state: FSM {INIT, RUN, MEM_WAIT}, counter cnt[CNT_W], MemTimeout, Ready. Stall, flush and forward outputs are combinational from state and inputs.
- Reset asserted (reset=0), async: state=INIT, cnt=0, Ready=0, MemTimeout=0. Reset mid-operation aborts any wait and restarts the INIT sequence.
- INIT: StallF=1, FlushD=FlushE=FlushW=1, StallD/E/M=0, Forward*=00. cnt increments each clk; at cnt==FLUSH_CYCLES-1 go to RUN and set Ready=1 next edge. Ready stays 1 until reset.
- RUN/MEM_WAIT, priority order:
  1. memwait = DMemReqM & ~DMemReadyM. If set: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. PCSrcE and the load-use condition are ignored while memwait=1; they are re-evaluated once the stall releases because E is held.
  2. Otherwise, if PCSrcE=1: FlushD=FlushE=1, no stalls. A taken branch overrides load-use, since the D instruction is squashed.
  3. Otherwise, load-use (LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D)): StallF=StallD=1, FlushE=1.
  4. Otherwise, all stall and flush outputs are 0.
- RUN→MEM_WAIT on memwait, with cnt cleared to 0. MEM_WAIT increments cnt each cycle, saturating at MEM_TIMEOUT. When cnt reaches MEM_TIMEOUT, MemTimeout is set (sticky until reset) and waiting continues. MEM_WAIT→RUN on the cycle DMemReadyM=1; stalls drop combinationally in that same cycle.
- A request with DMemReadyM=1 in the same cycle is a single-cycle access: no stall and no state change.
- Forwarding, evaluated per operand. For ForwardAE: 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE uses the same rule with Rs2E. M takes priority over W. x0 is never forwarded.

Decomposition:
- Package pipe_ctrl_pkg contains: the state enum (INIT, RUN, MEM_WAIT), forward select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, and the bubble value 0.
- One natural sub-module: forward_unit. It is purely combinational and is instantiated once per operand, or once with two outputs.

Test Plan:
- Reset release with FLUSH_CYCLES=2 → FlushD/E/W=1 and StallF=1 for exactly 2 cycles; Ready rises after the 2nd edge; outputs are then 0 with no hazards present.
- RdE=5, LoadE=1, Rs2D=5 → StallF=StallD=FlushE=1 for one cycle. The same case with RdE=0 → no stall.
- PCSrcE=1 together with a load-use condition → FlushD=FlushE=1, StallF=StallD=0.
- DMemReqM=1, DMemReadyM=0 for 3 cycles then 1 → StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, released in the ready cycle. A PCSrcE=1 held during the wait produces its flush only after release.
- MEM_TIMEOUT=4, ready withheld for 10 cycles → MemTimeout=1 once cnt reaches 4, and it stays 1 after ready returns until reset. Asserting reset mid-wait clears it and returns to INIT.
- Rs1E=7 with RdM=7/RegWriteM=1 and RdW=7/RegWriteW=1 → ForwardAE=10. Same with RegWriteM=0 → 01. Rs2E=0 with RdM=0 → ForwardBE=00.
